// File: rtl/addsub_pkg.sv
// Shared constants for the AddSub accumulator front-end: op codes, FSM
// state encodings and default widths.
package addsub_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic counts_as_op(input logic [1:0] op);
    return (op != OP_CLEAR);
  endfunction

endpackage

// File: rtl/addsub_accum_ctrl_if.sv
// Bundle of the request, response and AddSub-side signals of the
// accumulator controller; slave is the controller, master its environment.
interface addsub_accum_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;

  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic             as_ci;
  logic [WIDTH-1:0] as_sd;
  logic             as_co;
  logic             as_err;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             overflow;
  logic             sticky_err;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, in_op, in_data, out_ready, as_sd, as_co, as_err,
    output in_ready, as_a, as_b, as_ci, out_valid, acc, carry, overflow,
           sticky_err, op_count
  );

  modport master (
    output in_valid, in_op, in_data, out_ready, as_sd, as_co, as_err,
    input  in_ready, as_a, as_b, as_ci, out_valid, acc, carry, overflow,
           sticky_err, op_count
  );

endinterface

// File: rtl/addsub_accum_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/addsub_accum_ctrl.sv
// Sequential front-end for the external combinational AddSub: accepts an op,
// drives the adder from registers for one EXEC cycle, then holds the result.
module addsub_accum_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  addsub_accum_ctrl_if.slave  bus
);

  logic [1:0]       state_d, state_q;
  logic [1:0]       op_d, op_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic             ci_d, ci_q;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             sticky_d, sticky_q;
  logic             cnt_inc;
  logic             cnt_clr;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    ci_d     = ci_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          b_d     = bus.in_data;
          // Subtract select is registered so as_ci has no path from in_op.
          ci_d    = (bus.in_op == OP_SUB);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_LOAD: begin
            acc_d   = b_q;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc_d    = bus.as_sd;
            carry_d  = bus.as_co;
            ovf_d    = bus.as_err;
            sticky_d = sticky_q | bus.as_err;
          end
          default: begin
            acc_d    = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
          end
        endcase
        cnt_inc = counts_as_op(op_q);
        cnt_clr = !counts_as_op(op_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      b_q      <= '0;
      ci_q     <= 1'b0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_op_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (bus.op_count)
  );

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_RESP);
  assign bus.as_a       = acc_q;
  assign bus.as_b       = b_q;
  assign bus.as_ci      = ci_q;
  assign bus.acc        = acc_q;
  assign bus.carry      = carry_q;
  assign bus.overflow   = ovf_q;
  assign bus.sticky_err = sticky_q;

endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// Directed bench for addsub_accum_ctrl with a behavioural AddSub beside it,
// as the parent level would place the real unit.
module tb_addsub_accum_ctrl;
  import addsub_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   failed;
  logic exec_ci;

  addsub_accum_ctrl_if #(.WIDTH(8), .CNT_W(8)) bus ();

  addsub_accum_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the external AddSub unit.
  logic [7:0] adder_b;
  logic [8:0] adder_sum;
  always_comb begin
    adder_b    = bus.as_ci ? ~bus.as_b : bus.as_b;
    adder_sum  = {1'b0, bus.as_a} + {1'b0, adder_b} + {8'd0, bus.as_ci};
    bus.as_sd  = adder_sum[7:0];
    bus.as_co  = adder_sum[8];
    bus.as_err = (bus.as_a[7] == adder_b[7]) && (adder_sum[7] != bus.as_a[7]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] acc_e, input logic carry_e,
                              input logic ovf_e, input logic sticky_e, input logic [7:0] cnt_e);
    check({tag, "_acc"}, 32'(bus.acc), 32'(acc_e));
    check({tag, "_carry"}, 32'(bus.carry), 32'(carry_e));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf_e));
    check({tag, "_sticky"}, 32'(bus.sticky_err), 32'(sticky_e));
    check({tag, "_cnt"}, 32'(bus.op_count), 32'(cnt_e));
  endtask

  // Drive a request until accepted and follow it into RESP; the handshake
  // cycle counts as 0, so out_valid must first be seen in cycle 2.
  task automatic issue_op(input logic [1:0] op, input logic [7:0] data);
    int   waitc;
    int   lat;
    logic exec_ready;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = data;
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_wait", 32'(waitc < 50), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    exec_ci    = bus.as_ci;
    exec_ready = bus.in_ready;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    check("exec_in_ready", 32'(exec_ready), 32'd0);
  endtask

  task automatic release_resp();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    failed        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_LOAD;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    check_result("reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    issue_op(OP_LOAD, 8'd5);
    check_result("load5", 8'd5, 1'b0, 1'b0, 1'b0, 8'd1);
    release_resp();
    issue_op(OP_ADD, 8'd3);
    check("add3_ci", 32'(exec_ci), 32'd0);
    check_result("add3", 8'd8, 1'b0, 1'b0, 1'b0, 8'd2);
    release_resp();

    issue_op(OP_LOAD, 8'h01);
    release_resp();
    issue_op(OP_ADD, 8'hFF);
    check_result("add_wrap", 8'h00, 1'b1, 1'b0, 1'b0, 8'd4);
    release_resp();

    issue_op(OP_LOAD, 8'h7F);
    release_resp();
    issue_op(OP_ADD, 8'h01);
    check_result("add_ovf", 8'h80, 1'b0, 1'b1, 1'b1, 8'd6);
    release_resp();
    issue_op(OP_LOAD, 8'h02);
    check_result("load_after_ovf", 8'h02, 1'b0, 1'b0, 1'b1, 8'd7);
    release_resp();
    issue_op(OP_ADD, 8'h02);
    check_result("sticky_hold", 8'h04, 1'b0, 1'b0, 1'b1, 8'd8);
    release_resp();
    issue_op(OP_CLEAR, 8'hAA);
    check_result("clear", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    release_resp();

    issue_op(OP_LOAD, 8'h03);
    release_resp();
    issue_op(OP_SUB, 8'h05);
    check("sub_ci", 32'(exec_ci), 32'd1);
    check_result("sub_borrow", 8'hFE, 1'b0, 1'b0, 1'b0, 8'd2);
    release_resp();
    issue_op(OP_LOAD, 8'h05);
    release_resp();
    issue_op(OP_SUB, 8'h03);
    check_result("sub_noborrow", 8'h02, 1'b1, 1'b0, 1'b0, 8'd4);
    release_resp();

    issue_op(OP_LOAD, 8'h04);
    release_resp();
    issue_op(OP_ADD, 8'h01);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_data  = 8'h09;
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_acc", 32'(bus.acc), 32'h05);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue_op(OP_ADD, 8'h09);
    check_result("bp_add9", 8'h0E, 1'b0, 1'b0, 1'b0, 8'd7);
    release_resp();

    issue_op(OP_LOAD, 8'h05);
    release_resp();
    issue_op(OP_ADD, 8'hFF);
    check_result("pre_rst_exec", 8'h04, 1'b1, 1'b0, 1'b0, 8'd9);
    release_resp();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_data  = 8'h01;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_result("rst_exec", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    check("rst_exec_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_exec_in_ready", 32'(bus.in_ready), 32'd1);

    issue_op(OP_LOAD, 8'h7F);
    release_resp();
    issue_op(OP_ADD, 8'h01);
    check_result("pre_rst_resp", 8'h80, 1'b0, 1'b1, 1'b1, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    check_result("rst_resp", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
    check("rst_resp_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_resp_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 300; i++) begin
      issue_op(OP_ADD, 8'(i));
      release_resp();
    end
    check("saturate_cnt", 32'(bus.op_count), 32'd255);
    issue_op(OP_LOAD, 8'h11);
    check("saturate_hold", 32'(bus.op_count), 32'd255);
    release_resp();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
